// File: rtl/sram_bus_master_pkg.sv
// Shared types and defaults for the SRAM bus master: FSM encodings, window defaults, strobe bundle.
package sram_bus_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
    localparam int unsigned DEF_ADDR_W    = 20;
    localparam int unsigned RD_LAT_MAX    = 4;
    localparam int unsigned LAT_CNT_W     = $clog2(RD_LAT_MAX);

    typedef struct packed {
        logic       ce_n;
        logic       we_n;
        logic [3:0] be_n;
    } mem_cmd_t;

    localparam mem_cmd_t MEM_CMD_IDLE = '{ce_n: 1'b1, we_n: 1'b1, be_n: 4'hF};

endpackage

// File: rtl/sram_bus_master_lat_cnt.sv
// Loadable down-counter; zero_c marks the cycle in which read data is to be captured.
module sram_lat_cnt
    import sram_bus_master_pkg::*;
#(
    parameter int unsigned W = LAT_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero_c
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_c = en & (cnt_q == '0);

endmodule

// File: rtl/sram_bus_master.sv
// Initiator for the SRAM-style memory port: window check, single access strobe, one-cycle response.
// Define SRAM_POSTED_WRITE_EN to return write responses in the strobe cycle.
module sram_bus_master
    import sram_bus_master_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_ce_n,
    output logic              mem_we_n,
    output logic [3:0]        mem_be_n,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned         TAG_LSB  = ADDR_W + 2;
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    mem_cmd_t          cmd_d;
    logic              resp_valid_d, resp_err_d;
    logic [31:0]       resp_rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              accept_c, hit_c, strobe_c, cap_c;
    logic              unused_addr_lsb;

    assign req_ready       = (state_q == ST_IDLE) & rst;
    assign accept_c        = req_valid & req_ready;
    assign hit_c           = (req_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign strobe_c        = ~req_we | (req_be != 4'h0);
    assign unused_addr_lsb = ^req_addr[1:0];

    sram_lat_cnt #(.W(LAT_CNT_W)) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     ((state_q == ST_ISSUE) & ~we_q),
        .load_val (LAT_LOAD),
        .en       (state_q == ST_WAIT),
        .zero_c   (cap_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept_c) state_d = hit_c ? ST_ISSUE : ST_ERR;
`ifdef SRAM_POSTED_WRITE_EN
            ST_ISSUE: state_d = we_q ? ST_IDLE : ST_WAIT;
`else
            ST_ISSUE: state_d = we_q ? ST_RESP : ST_WAIT;
`endif
            ST_WAIT:  if (cap_c) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; they take effect in the cycle after the edge.
    always_comb begin
        cmd_d        = MEM_CMD_IDLE;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        we_d         = we_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c && hit_c) begin
                    mem_addr_d  = req_addr[TAG_LSB-1:2];
                    mem_wdata_d = req_wdata;
                    we_d        = req_we;
                    cmd_d.ce_n  = ~strobe_c;
                    cmd_d.we_n  = ~(req_we & strobe_c);
                    cmd_d.be_n  = req_we ? ~req_be : 4'h0;
`ifdef SRAM_POSTED_WRITE_EN
                    resp_valid_d = req_we;
`else
                    resp_valid_d = 1'b0;
`endif
                end else if (accept_c) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end
            end
            ST_ISSUE: begin
`ifdef SRAM_POSTED_WRITE_EN
                resp_valid_d = 1'b0;
`else
                resp_valid_d = we_q;
`endif
            end
            ST_WAIT: begin
                if (cap_c) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q       <= 1'b0;
            mem_ce_n   <= 1'b1;
            mem_we_n   <= 1'b1;
            mem_be_n   <= 4'hF;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            we_q       <= we_d;
            mem_ce_n   <= cmd_d.ce_n;
            mem_we_n   <= cmd_d.we_n;
            mem_be_n   <= cmd_d.be_n;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_sram_bus_master.sv
// Directed bench for sram_bus_master: two instances (RD_LAT=1 and RD_LAT=3) with pipelined memory models.
module tb_sram_bus_master;

`ifdef SRAM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        va, vb;

    logic        rdy_a, rv_a, err_a, ce_a, we_a;
    logic [31:0] rd_a, wd_a, mrd_a;
    logic [19:0] ad_a;
    logic [3:0]  be_a;
    logic        rdy_b, rv_b, err_b, ce_b, we_b;
    logic [31:0] rd_b, wd_b, mrd_b;
    logic [19:0] ad_b;
    logic [3:0]  be_b;

    sram_bus_master #(.RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(va), .req_ready(rdy_a), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(rv_a), .resp_rdata(rd_a), .resp_err(err_a),
        .mem_addr(ad_a), .mem_wdata(wd_a), .mem_ce_n(ce_a), .mem_we_n(we_a),
        .mem_be_n(be_a), .mem_rdata(mrd_a)
    );

    sram_bus_master #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .req_valid(vb), .req_ready(rdy_b), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(rv_b), .resp_rdata(rd_b), .resp_err(err_b),
        .mem_addr(ad_b), .mem_wdata(wd_b), .mem_ce_n(ce_b), .mem_we_n(we_b),
        .mem_be_n(be_b), .mem_rdata(mrd_b)
    );

    function automatic logic [31:0] mem_val(input logic [19:0] a);
        return (a == 20'h4) ? 32'hDEAD_BEEF : {12'hA5A, a};
    endfunction

    // Memory models: data only valid exactly RD_LAT edges after the ce sample edge.
    logic        pa_v = 1'b0;
    logic [31:0] pa_d = '0;
    always @(posedge clk) begin
        pa_v <= !ce_a && we_a;
        pa_d <= mem_val(ad_a);
    end
    assign mrd_a = pa_v ? pa_d : 32'h0BAD_0BAD;

    logic [2:0]  pb_v = '0;
    logic [31:0] pb_d0 = '0, pb_d1 = '0, pb_d2 = '0;
    always @(posedge clk) begin
        pb_v  <= {pb_v[1:0], !ce_b && we_b};
        pb_d0 <= mem_val(ad_b);
        pb_d1 <= pb_d0;
        pb_d2 <= pb_d1;
    end
    assign mrd_b = pb_v[2] ? pb_d2 : 32'h0BAD_0BAD;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d);
        req_we    = we;
        req_addr  = a;
        req_be    = be;
        req_wdata = d;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  k;
        logic seen;
        va = 1'b0;
        vb = 1'b0;
        set_req(1'b0, 32'h0, 4'h0, 32'h0);
        #1 rst = 1'b0;
        #1;
        check("rst_ready",  32'(rdy_a), 32'h0);
        check("rst_ce_n",   32'(ce_a),  32'h1);
        check("rst_we_n",   32'(we_a),  32'h1);
        check("rst_be_n",   32'(be_a),  32'hF);
        check("rst_addr",   32'(ad_a),  32'h0);
        check("rst_wdata",  wd_a,       32'h0);
        check("rst_rvalid", 32'(rv_a),  32'h0);
        check("rst_rdata",  rd_a,       32'h0);
        check("rst_err",    32'(err_a), 32'h0);
        repeat (2) tick();
        check("rst_ready_clk", 32'(rdy_b), 32'h0);
        rst = 1'b1;
        #1;
        check("ready_after_rst", 32'(rdy_a), 32'h1);

        // Read hit, RD_LAT=1
        set_req(1'b0, 32'h8000_0010, 4'hF, 32'h0);
        va = 1'b1;
        tick();
        va = 1'b0;
        set_req(1'b1, 32'h0000_0000, 4'h0, 32'hFFFF_FFFF);
        check("rd_ce_n",  32'(ce_a),  32'h0);
        check("rd_addr",  32'(ad_a),  32'h4);
        check("rd_we_n",  32'(we_a),  32'h1);
        check("rd_be_n",  32'(be_a),  32'h0);
        check("rd_busy",  32'(rdy_a), 32'h0);
        check("rd_early", 32'(rv_a),  32'h0);
        tick();
        check("rd_ce_pulse", 32'(ce_a), 32'h1);
        check("rd_wait_rv",  32'(rv_a), 32'h0);
        tick();
        check("rd_rv",    32'(rv_a),  32'h1);
        check("rd_rdata", rd_a,       32'hDEAD_BEEF);
        check("rd_err",   32'(err_a), 32'h0);
        tick();
        check("rd_rv_off", 32'(rv_a),  32'h0);
        check("rd_idle",   32'(rdy_a), 32'h1);

        // Write hit with partial byte enables
        set_req(1'b1, 32'h8000_0004, 4'b0011, 32'h1234_5678);
        va = 1'b1;
        tick();
        va = 1'b0;
        set_req(1'b0, 32'h0, 4'h0, 32'h0);
        check("wr_ce_n",  32'(ce_a), 32'h0);
        check("wr_we_n",  32'(we_a), 32'h0);
        check("wr_be_n",  32'(be_a), 32'hC);
        check("wr_addr",  32'(ad_a), 32'h1);
        check("wr_wdata", wd_a,      32'h1234_5678);
        check("wr_rv_n1", 32'(rv_a), 32'(POSTED));
        tick();
        check("wr_ce_off", 32'(ce_a),  32'h1);
        check("wr_we_off", 32'(we_a),  32'h1);
        check("wr_be_off", 32'(be_a),  32'hF);
        check("wr_rv_n2",  32'(rv_a),  32'(!POSTED));
        check("wr_err",    32'(err_a), 32'h0);
        check("wr_rdata",  rd_a,       32'h0);
        check("wr_rdy_n2", 32'(rdy_a), 32'(POSTED));
        tick();
        check("wr_rdy_n3", 32'(rdy_a), 32'h1);

        // Write with no byte enables: no strobe, normal response timing
        set_req(1'b1, 32'h8000_0008, 4'h0, 32'hAAAA_AAAA);
        va = 1'b1;
        tick();
        va = 1'b0;
        check("wr0_ce_n", 32'(ce_a), 32'h1);
        check("wr0_we_n", 32'(we_a), 32'h1);
        check("wr0_rv_n1", 32'(rv_a), 32'(POSTED));
        tick();
        check("wr0_rv_n2", 32'(rv_a), 32'(!POSTED));
        tick();

        // Out-of-window read
        set_req(1'b0, 32'h0000_1000, 4'hF, 32'h0);
        va = 1'b1;
        tick();
        va = 1'b0;
        check("err_ce_n",  32'(ce_a),  32'h1);
        check("err_rv",    32'(rv_a),  32'h1);
        check("err_flag",  32'(err_a), 32'h1);
        check("err_rdata", rd_a,       32'h0);
        check("err_addr_hold", 32'(ad_a), 32'h2);
        tick();
        check("err_rv_off", 32'(rv_a),  32'h0);
        check("err_idle",   32'(rdy_a), 32'h1);

        // Back-to-back write then read with valid held high
        set_req(1'b1, 32'h8000_000C, 4'hF, 32'hCAFE_F00D);
        va = 1'b1;
        tick();
        set_req(1'b0, 32'h8000_0010, 4'hF, 32'h0);
        check("b2b_wresp", 32'(rv_a), 32'(POSTED));
        k = 1;
        while (!rdy_a && k < 6) begin
            tick();
            k++;
        end
        check("b2b_acc_edge", 32'(k), POSTED ? 32'd2 : 32'd3);
        tick();
        va = 1'b0;
        check("b2b_rd_ce",   32'(ce_a), 32'h0);
        check("b2b_rd_addr", 32'(ad_a), 32'h4);
        tick();
        tick();
        check("b2b_rd_rv",    32'(rv_a), 32'h1);
        check("b2b_rd_rdata", rd_a,      32'hDEAD_BEEF);
        tick();

        // RD_LAT=3 at the last word of the window, then one word past it
        set_req(1'b0, 32'h803F_FFFC, 4'hF, 32'h0);
        vb = 1'b1;
        tick();
        vb = 1'b0;
        check("lat3_ce",   32'(ce_b), 32'h0);
        check("lat3_addr", 32'(ad_b), 32'hF_FFFF);
        repeat (3) tick();
        check("lat3_early", 32'(rv_b), 32'h0);
        tick();
        check("lat3_rv",    32'(rv_b),  32'h1);
        check("lat3_rdata", rd_b,       32'hA5AF_FFFF);
        check("lat3_err",   32'(err_b), 32'h0);
        tick();
        set_req(1'b0, 32'h8040_0000, 4'hF, 32'h0);
        vb = 1'b1;
        tick();
        vb = 1'b0;
        check("wrap_err", 32'(err_b), 32'h1);
        check("wrap_rv",  32'(rv_b),  32'h1);
        check("wrap_ce",  32'(ce_b),  32'h1);
        tick();

        // Reset asserted while waiting for read data
        set_req(1'b0, 32'h8000_0010, 4'hF, 32'h0);
        vb = 1'b1;
        tick();
        vb = 1'b0;
        tick();
        check("wait_busy", 32'(rdy_b), 32'h0);
        #2 rst = 1'b0;
        #1;
        check("arst_ce_n",  32'(ce_b),  32'h1);
        check("arst_we_n",  32'(we_b),  32'h1);
        check("arst_be_n",  32'(be_b),  32'hF);
        check("arst_rv",    32'(rv_b),  32'h0);
        check("arst_ready", 32'(rdy_b), 32'h0);
        tick();
        #2 rst = 1'b1;
        #1;
        check("rel_ready", 32'(rdy_b), 32'h1);
        tick();
        check("rel_ready_edge", 32'(rdy_b), 32'h1);
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (rv_b !== 1'b0) seen = 1'b1;
        end
        check("no_stale_resp", 32'(seen), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
